// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with illegal-opcode and memory-timeout traps.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control_fsm #(
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    input  logic                branch_taken,
    input  logic                trap_clr,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                jump,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_cause
`ifdef CTRL_PERF_CNT_EN
   ,output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_retired
`endif
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Last MEM wait cycle index; a cycle at this count without mem_ready traps.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    if (ALU_OP_W < 2 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
        $error("multicycle_control_fsm: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_LUI, K_ILLEGAL
    } kind_t;

    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] cause_q, cause_d;
    kind_t      kind;
    logic [1:0] alu_class;

    always_comb begin
        unique case (op_q)
            OPC_R:      kind = K_R;
            OPC_I:      kind = K_I;
            OPC_LOAD:   kind = K_LOAD;
            OPC_STORE:  kind = K_STORE;
            OPC_BRANCH: kind = K_BRANCH;
            OPC_JAL:    kind = K_JAL;
            OPC_LUI:    kind = K_LUI;
            default:    kind = K_ILLEGAL;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        tmo_d   = tmo_q;
        cause_d = cause_q;
        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (kind == K_ILLEGAL) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (kind == K_LOAD || kind == K_STORE) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else if (kind == K_BRANCH) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A ready on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    state_d = (kind == K_LOAD) ? S_WB : S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: state_d = S_FETCH;
            S_TRAP: begin
                if (trap_clr) begin
                    state_d = S_FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            tmo_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            op_q    <= op_d;
            tmo_q   <= tmo_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        // NOTE: the accept pulse is gated by rst_n so every output is low while reset is held.
        ir_write   = rst_n & instr_valid & (state_q == S_FETCH);
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_class  = ALU_ADD;
        busy       = (state_q != S_FETCH);
        trap       = (state_q == S_TRAP);
        trap_cause = cause_q;
        unique case (state_q)
            S_EXEC: begin
                unique case (kind)
                    K_R:     alu_class = ALU_FUNCT;
                    K_I: begin
                        alu_src   = 1'b1;
                        alu_class = ALU_FUNCT;
                    end
                    K_LOAD, K_STORE, K_LUI: alu_src = 1'b1;
                    K_BRANCH: begin
                        branch    = 1'b1;
                        alu_class = ALU_SUB;
                        pc_write  = branch_taken;
                    end
                    K_JAL: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_read  = (kind == K_LOAD);
                mem_write = (kind == K_STORE);
                pc_write  = (kind == K_STORE) & mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (kind == K_LOAD);
                jump       = (kind == K_JAL);
                pc_write   = (kind != K_JAL);
            end
            default: ;
        endcase
        alu_op = ALU_OP_W'(alu_class);
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, cycle_d, retired_q, retired_d;
    logic             retire;

    always_comb begin
        // Every exit to FETCH except the one out of TRAP retires an instruction.
        retire = (state_q == S_WB)
               | (state_q == S_EXEC && kind == K_BRANCH)
               | (state_q == S_MEM && kind == K_STORE && mem_ready);
        cycle_d   = cycle_q + CNT_W'(busy);
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    assign cycle_cnt     = cycle_q;
    assign instr_retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle vector table built from an
// instruction-level model, plus reset and reset-abort sequences.
module tb_multicycle_control_fsm;

    localparam int ALU_OP_W    = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 16;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n;
    logic instr_valid, mem_ready, branch_taken, trap_clr;
    logic [6:0] opcode;
    logic ir_write, pc_write, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, jump;
    logic [ALU_OP_W-1:0] alu_op;
    logic busy, trap;
    logic [1:0] trap_cause;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, instr_retired;
`endif

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .ALU_OP_W(ALU_OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .trap_clr(trap_clr),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .alu_op(alu_op), .busy(busy), .trap(trap),
        .trap_cause(trap_cause)
`ifdef CTRL_PERF_CNT_EN
       ,.cycle_cnt(cycle_cnt), .instr_retired(instr_retired)
`endif
    );

    // Expected word: {ir,pc,rw,alu_src,mem_to_reg,mem_read,mem_write,branch,jump,alu_op[2:0],busy,trap,cause[1:0]}
    typedef struct {
        logic        iv;
        logic [6:0]  op;
        logic        mr;
        logic        bt;
        logic        tc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_busy_cycles = 0;
    int   exp_retired     = 0;

    wire [15:0] dut_out = {ir_write, pc_write, reg_write, alu_src, mem_to_reg, mem_read,
                           mem_write, branch, jump, alu_op, busy, trap, trap_cause};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mk(input logic ir, pc, rw, as, mtr, mr, mw, br, j,
                                       input logic [2:0] aop, input logic bsy, trp,
                                       input logic [1:0] cause);
        return {ir, pc, rw, as, mtr, mr, mw, br, j, aop, bsy, trp, cause};
    endfunction

    // Instruction class: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 illegal
    function automatic int klass(input logic [6:0] op);
        case (op)
            OP_R:    return 0;
            OP_I:    return 1;
            OP_LD:   return 2;
            OP_ST:   return 3;
            OP_BR:   return 4;
            OP_JAL:  return 5;
            OP_LUI:  return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    task automatic push(input logic iv, input logic [6:0] op, input logic mr, input logic bt,
                        input logic tc, input logic [15:0] exp);
        vec_t v;
        v.iv = iv; v.op = op; v.mr = mr; v.bt = bt; v.tc = tc; v.exp = exp;
        vecs.push_back(v);
        if (exp[3]) exp_busy_cycles++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, r7(), r1(), r1(), r1(), 16'h0000);
    endtask

    task automatic trap_seq(input logic [1:0] cause, input int hold);
        for (int i = 0; i < hold; i++)
            push(r1(), r7(), r1(), r1(), 1'b0, mk(0,0,0,0,0,0,0,0,0,3'd0,1,1,cause));
        push(r1(), r7(), r1(), r1(), 1'b1, mk(0,0,0,0,0,0,0,0,0,3'd0,1,1,cause));
    endtask

    // wait_n: MEM cycles without mem_ready before the ready one; >= MEM_TIMEOUT means never ready.
    task automatic add_instr(input logic [6:0] op, input logic bt, input int wait_n, input int trap_hold);
        int k;
        logic ld, st, rdy;
        k  = klass(op);
        ld = (k == 2);
        st = (k == 3);
        push(1'b1, op, r1(), r1(), r1(), mk(1,0,0,0,0,0,0,0,0,3'd0,0,0,2'b00));
        push(r1(), r7(), r1(), r1(), r1(), mk(0,0,0,0,0,0,0,0,0,3'd0,1,0,2'b00));
        if (k == 7) begin
            trap_seq(2'b01, trap_hold);
            return;
        end
        case (k)
            0: push(r1(), r7(), r1(), r1(), r1(), mk(0,0,0,0,0,0,0,0,0,3'd2,1,0,2'b00));
            1: push(r1(), r7(), r1(), r1(), r1(), mk(0,0,0,1,0,0,0,0,0,3'd2,1,0,2'b00));
            4: push(r1(), r7(), r1(), bt,   r1(), mk(0,bt,0,0,0,0,0,1,0,3'd1,1,0,2'b00));
            5: push(r1(), r7(), r1(), r1(), r1(), mk(0,1,0,0,0,0,0,0,1,3'd0,1,0,2'b00));
            default: push(r1(), r7(), r1(), r1(), r1(), mk(0,0,0,1,0,0,0,0,0,3'd0,1,0,2'b00));
        endcase
        if (k == 4) begin
            exp_retired++;
            return;
        end
        if (ld || st) begin
            for (int i = 0; i < MEM_TIMEOUT; i++) begin
                rdy = (i == wait_n);
                push(r1(), r7(), rdy, r1(), r1(), mk(0,st & rdy,0,0,0,ld,st,0,0,3'd0,1,0,2'b00));
                if (rdy) break;
            end
            if (wait_n >= MEM_TIMEOUT) begin
                trap_seq(2'b10, trap_hold);
                return;
            end
            if (st) begin
                exp_retired++;
                return;
            end
        end
        push(r1(), r7(), r1(), r1(), r1(), mk(0,(k != 5),1,0,ld,0,0,0,(k == 5),3'd0,1,0,2'b00));
        exp_retired++;
    endtask

    task automatic drive(input vec_t v);
        instr_valid  = v.iv;
        opcode       = v.op;
        mem_ready    = v.mr;
        branch_taken = v.bt;
        trap_clr     = v.tc;
    endtask

    initial begin
        logic [6:0] ill;
        logic [6:0] legal_ops [7];
        legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI};

        rst_n = 1'b0;
        instr_valid = 1'b1; opcode = OP_R; mem_ready = 1'b1; branch_taken = 1'b1; trap_clr = 1'b0;
        #3;
        check("reset_outputs", 64'(dut_out), 64'h0);
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b1;

        // Reset abort: LOAD reaches MEM, then rst_n drops mid-cycle.
        @(posedge clk); #1;
        instr_valid = 1'b1; opcode = OP_LD; mem_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_mem_read_before", 64'(mem_read), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs_async", 64'(dut_out), 64'h0);
`ifdef CTRL_PERF_CNT_EN
        check("abort_cycle_cnt", 64'(cycle_cnt), 64'h0);
        check("abort_instr_retired", 64'(instr_retired), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_clean_fetch", 64'(dut_out), 64'h0);

        // Directed corner cases.
        add_instr(OP_R, 1'b0, 0, 0);
        idle(1);
        add_instr(OP_LD, 1'b0, 3, 0);
        add_instr(OP_BR, 1'b1, 0, 0);
        add_instr(OP_BR, 1'b0, 0, 0);
        add_instr(7'b1111111, 1'b0, 0, 2);
        idle(1);
        add_instr(OP_ST, 1'b0, MEM_TIMEOUT, 1);
        add_instr(OP_ST, 1'b0, MEM_TIMEOUT - 1, 0);
        add_instr(OP_JAL, 1'b0, 0, 0);
        add_instr(OP_I, 1'b0, 0, 0);
        add_instr(OP_LUI, 1'b0, 0, 0);
        add_instr(OP_LD, 1'b0, MEM_TIMEOUT + 1, 0);
        add_instr(OP_LD, 1'b0, 0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(7) == 0) begin
                do ill = r7(); while (klass(ill) != 7);
                add_instr(ill, r1(), 0, $urandom_range(2));
            end else begin
                add_instr(legal_ops[$urandom_range(6)], r1(), $urandom_range(MEM_TIMEOUT + 1),
                          $urandom_range(2));
            end
            idle($urandom_range(2));
        end
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(dut_out), 64'(vecs[i].exp));
            check($sformatf("vec%0d_rw_mw_excl", i), 64'(reg_write & mem_write), 64'h0);
            check($sformatf("vec%0d_mr_mw_excl", i), 64'(mem_read & mem_write), 64'h0);
            @(posedge clk); #1;
        end

`ifdef CTRL_PERF_CNT_EN
        check("cycle_cnt_total", 64'(cycle_cnt), 64'(CNT_W'(exp_busy_cycles)));
        check("instr_retired_total", 64'(instr_retired), 64'(CNT_W'(exp_retired)));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised multicycle successor to the single-cycle opcode decoder in the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle.
- Decodes R, I-ALU, LOAD, STORE, BRANCH, JAL and LUI.
- Handshakes with instruction fetch (instr_valid) and data memory (mem_ready).
- Traps on illegal opcodes and on a data-memory timeout; sits between the IR/fetch unit and the datapath muxes and enables.

Parameters:
ALU_OP_W, 2, width of alu_op (2'b00 add, 2'b01 sub/compare, 2'b10 funct-decoded); must be >= 2, upper bits zero.
MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ready before trap; range 1..255.
CNT_W, 32, width of performance counters (optional feature only).

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  fetch has a valid instruction on opcode
opcode  in  7  instruction[6:0], sampled when instr_valid accepted
mem_ready  in  1  data memory completed the current read/write
branch_taken  in  1  ALU compare result, valid in EXEC
trap_clr  in  1  leave TRAP state
ir_write  out  1  latch instruction register (accept pulse)
pc_write  out  1  update PC
reg_write  out  1  register file write enable
alu_src  out  1  1 = immediate operand B
mem_to_reg  out  1  1 = writeback from memory
mem_read  out  1  data memory read request
mem_write  out  1  data memory write request
branch  out  1  branch instruction in EXEC
jump  out  1  JAL in EXEC/WB
alu_op  out  ALU_OP_W  ALU operation class
busy  out  1  high in every state except FETCH
trap  out  1  high in TRAP
trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH, op_q = 0, timeout counter = 0, trap_cause = 0. Every output is 0.
- op_q is a 7-bit opcode register, loaded only when ir_write = 1. Outputs are decoded combinationally from state and op_q (Moore), except ir_write = (state==FETCH) & instr_valid.
- FETCH: wait for instr_valid.
  - On instr_valid: ir_write = 1, load op_q, go to DECODE.
  - Without instr_valid: stay in FETCH, all outputs 0.
- DECODE (1 cycle):
  - Legal op_q (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111) -> EXEC.
  - Any other value -> TRAP with trap_cause = 01.
- EXEC (1 cycle):
  - R: alu_src = 0, alu_op = 10.
  - I-ALU: alu_src = 1, alu_op = 10.
  - LOAD/STORE: alu_src = 1, alu_op = 00.
  - BRANCH: branch = 1, alu_op = 01, pc_write = branch_taken.
  - JAL: jump = 1, pc_write = 1.
  - LUI: alu_src = 1, alu_op = 00.
- Next state after EXEC: LOAD/STORE -> MEM; BRANCH -> FETCH (pc_write asserted as above); all others -> WB.
- MEM:
  - mem_read (LOAD) or mem_write (STORE) is held high until mem_ready.
  - The timeout counter clears on MEM entry and increments each MEM cycle without mem_ready.
  - mem_ready -> WB (LOAD) or FETCH with pc_write = 1 (STORE).
  - Counter reaches MEM_TIMEOUT with no mem_ready -> TRAP with trap_cause = 10. The request drops in the same cycle.
  - mem_ready in the same cycle the counter hits the limit counts as success; no trap.
- WB (1 cycle): reg_write = 1. mem_to_reg = 1 for LOAD only. jump = 1 for JAL. pc_write = 1 for all WB ops except JAL, whose PC already updated in EXEC. Next state FETCH.
- TRAP: trap = 1, all other outputs 0, busy = 1. trap_clr -> FETCH and trap_cause cleared next cycle. instr_valid is ignored in TRAP.
- Cycles from accept to return to FETCH:
  - R / I / LUI / JAL: 4.
  - BRANCH: 3.
  - STORE: 4 + wait cycles.
  - LOAD: 5 + wait cycles.
- reg_write and mem_write are never high in the same cycle. mem_read and mem_write are never both high.
- Reset asserted mid-instruction aborts immediately. The returned FETCH is clean, with no residual request.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: adds outputs cycle_cnt [CNT_W] and instr_retired [CNT_W].
  - cycle_cnt increments every cycle that busy = 1.
  - instr_retired increments on each exit to FETCH from WB, EXEC (branch) or MEM (store).
  - Both counters wrap at 2^CNT_W. Reset clears both to 0; entering TRAP does not clear them.
- Undefined: no counter ports or logic; behaviour is otherwise identical.

Test Plan:
- R-type 0110011 with instr_valid pulse -> ir_write in cycle 0, alu_op = 10 in EXEC, reg_write = 1 exactly once in WB, back in FETCH at cycle 4.
- LOAD 0000011, mem_ready after 3 wait cycles -> mem_read high for 4 cycles, then WB with mem_to_reg = 1 and reg_write = 1, total 8 cycles.
- BRANCH 1100011 with branch_taken = 1, then a second BRANCH with branch_taken = 0 -> pc_write = 1 in the first EXEC only, no reg_write in either, 3 cycles each.
- Opcode 1111111 -> TRAP after DECODE with trap_cause = 01 and all enables 0. trap_clr -> FETCH, trap_cause = 00.
- STORE with mem_ready held 0, MEM_TIMEOUT = 4 -> mem_write high for 4 cycles, then trap = 1 with trap_cause = 10. Rerun with mem_ready on the 4th cycle -> no trap.
- rst_n low during MEM of a LOAD -> mem_read drops asynchronously, FETCH after release. With CTRL_PERF_CNT_EN, counters read 0.
